tmds_channel_array: RTL and testbench
=====================================

Name: tmds_channel_array

Overview:
- Parametrised multi-lane TMDS encoder for HDMI 1.4a: video 8b/10b with per-lane running disparity, control symbols, TERC4 data-island symbols, video and data-island guard bands.
- Replaces per-lane single-cycle encoder instances in the HDMI top level with one N-lane block.
- Adds an optional two-stage pipeline for timing closure, plus a per-lane running-disparity debug output.
- The mode select is shared by all lanes; lane c uses the guard-band pattern for channel c.

Parameters:
- NUM_CHANNELS, 3, number of TMDS lanes (1..3); lane index = HDMI channel number.
- PIPELINED, 1, 0 = single-register path (latency 1); 1 = two-stage pipeline (latency 2).

Ports:
- clk_pixel  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- video_data  in  8*NUM_CHANNELS  lane c at [8c+7:8c].
- data_island_data  in  4*NUM_CHANNELS  TERC4 nibble per lane.
- control_data  in  2*NUM_CHANNELS  {C1,C0} per lane; lane 0 also selects its data guard band.
- mode  in  3  0 control, 1 video, 2 video guard, 3 island, 4 island guard, 5-7 illegal.
- tmds  out  10*NUM_CHANNELS  encoded symbol per lane, registered.
- disparity  out  5*NUM_CHANNELS  signed running disparity per lane, registered.

Behaviour:
- Decided: one clock, clk_pixel. Reset reset_n is asynchronous, active-low.
- Reset (async assert, sync release):
  - every tmds lane = 10'b1101010100 (control 00);
  - every disparity lane = 0;
  - all pipeline registers cleared, with stage-1 mode forced to 0.
- Latency:
  - inputs sampled at edge k appear on tmds at edge k+1 when PIPELINED=0, k+2 when PIPELINED=1;
  - one symbol per clock, no stalls;
  - all lanes stay cycle-aligned.
- Stage 1, registered only when PIPELINED=1:
  - N1D = popcount(video_data);
  - if N1D>4, or N1D==4 with d[0]==0: XNOR chain, q_m[8]=0; otherwise XOR chain, q_m[8]=1;
  - compute N1 = popcount(q_m[7:0]) and N0 = 8-N1;
  - precompute the control, TERC4 and guard symbols;
  - carry mode forward.
- Stage 2, per lane, using the stage-1 mode:
  - if acc==0 or N1==N0: output {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; acc_add = q_m8 ? N1-N0 : N0-N1.
  - else if (acc>0 and N1>N0) or (acc<0 and N1<N0): output {1, q_m8, ~q_m[7:0]}; acc_add = N0-N1 + 2*q_m8.
  - else: output {0, q_m8, q_m[7:0]}; acc_add = N1-N0 - 2*~q_m8.
- Disparity arithmetic:
  - acc is 5-bit signed, two's complement; legal range -10..+10, never wraps;
  - acc <= acc+acc_add when stage-2 mode==1, else acc <= 0;
  - the disparity port equals acc.
- Control codes: 00 = 1101010100, 01 = 0010101011, 10 = 0101010100, 11 = 1010101011.
- TERC4: standard HDMI 1.4a 16-entry table (0000 = 1010011100 ... 1111 = 1011000011).
- Video guard band: lanes 0 and 2 = 1011001100; lane 1 = 0100110011.
- Data-island guard band:
  - lanes 1 and 2 = 0100110011;
  - lane 0 = TERC4 code of {2'b11, control_data[1:0] of lane 0}: 00 = 1010001110, 01 = 1001110001, 10 = 0101100011, 11 = 1011000011.
- Illegal mode 5-7:
  - tmds holds its previous value;
  - acc resets to 0, as for any non-video mode.
- Mode change into video: the first video symbol is encoded with acc==0.
- Reset mid-stream: outputs return to reset values immediately; in-flight pipeline symbols are discarded.

Decomposition:
- Package tmds_pkg holds:
  - mode enum (CONTROL, VIDEO, VIDEO_GUARD, ISLAND, ISLAND_GUARD);
  - control-code constants;
  - TERC4 lookup function;
  - video and data guard-band constant functions indexed by channel number.
- Sub-module tmds_video_stage1:
  - per-lane q_m generation and N1/N0 popcount;
  - optionally registered by PIPELINED;
  - instantiated NUM_CHANNELS times by a generate loop.
- Disparity decision and output mux live inline per lane.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> every tmds lane = 10'b1101010100, disparity = 0; release, then mode=0 with control_data lane0 = 2'b11 -> tmds lane0 = 1010101011 after the parameter's latency.
- Video 0x00 held on lane 0 from acc=0 -> tmds sequence 0100000000, 1111111111, 0100000000; disparity sequence -8, +2, -6.
- mode=2 -> lanes 0 and 2 = 1011001100, lane 1 = 0100110011; mode=4 with lane0 control_data = 2'b10 -> lane0 = 0101100011, lanes 1 and 2 = 0100110011.
- mode=3 with data_island_data = 4'b0101 on all lanes -> every lane = 0100011110; nibble 4'b1111 -> 1011000011.
- Video stream with disparity nonzero, then mode 0 for one cycle, then video 0x00 again -> disparity reads 0, and the first symbol is 0100000000.
- Apply mode=6 -> tmds holds its prior value and disparity=0. Assert reset_n mid-video stream -> outputs return to reset values asynchronously. Repeat all cases for PIPELINED 0 and 1 and NUM_CHANNELS 1 and 3.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: mode encoding, control codes, TERC4 table and
// guard-band symbols indexed by HDMI channel number.
package tmds_pkg;

    typedef enum logic [2:0] {
        CONTROL      = 3'd0,
        VIDEO        = 3'd1,
        VIDEO_GUARD  = 3'd2,
        ISLAND       = 3'd3,
        ISLAND_GUARD = 3'd4
    } tmds_mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [9:0] control_code(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] d);
        case (d)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    function automatic logic [9:0] video_guard(input int ch);
        return (ch == 1) ? 10'b0100110011 : 10'b1011001100;
    endfunction

    // Lane 0 carries HSYNC/VSYNC inside its data-island guard band.
    function automatic logic [9:0] data_guard(input int ch, input logic [1:0] c0);
        return (ch == 0) ? terc4({2'b11, c0}) : 10'b0100110011;
    endfunction

endpackage

// File: rtl/tmds_channel_array_if.sv
// Parallel pixel-side bus of the N-lane TMDS encoder.
interface tmds_channel_array_if #(
    parameter int NUM_CHANNELS = 3
);
    logic [8*NUM_CHANNELS-1:0]  video_data;
    logic [4*NUM_CHANNELS-1:0]  data_island_data;
    logic [2*NUM_CHANNELS-1:0]  control_data;
    logic [2:0]                 mode;
    logic [10*NUM_CHANNELS-1:0] tmds;
    logic [5*NUM_CHANNELS-1:0]  disparity;

    modport master (
        output video_data, data_island_data, control_data, mode,
        input  tmds, disparity
    );

    modport slave (
        input  video_data, data_island_data, control_data, mode,
        output tmds, disparity
    );
endinterface

// File: rtl/tmds_video_stage1.sv
// Per-lane front half: transition-minimised q_m, its popcount and the
// precomputed non-video symbol, optionally registered.
module tmds_video_stage1
    import tmds_pkg::*;
#(
    parameter int CHANNEL   = 0,
    parameter int PIPELINED = 1
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [7:0] video_data,
    input  logic [3:0] data_island_data,
    input  logic [1:0] control_data,
    input  logic [1:0] guard_ctrl,
    input  logic [2:0] mode,
    output logic [8:0] q_m,
    output logic [3:0] n1,
    output logic [3:0] n0,
    output logic [9:0] symbol,
    output logic [2:0] mode_s1
);

    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] qm_c;
    logic [3:0] n1_c;
    logic [3:0] n0_c;
    logic [9:0] sym_c;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < 8; i++) ones += 4'(video_data[i]);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !video_data[0]);

        qm_c    = '0;
        qm_c[0] = video_data[0];
        for (int unsigned i = 1; i < 8; i++)
            qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ video_data[i]) : (qm_c[i-1] ^ video_data[i]);
        qm_c[8] = ~use_xnor;

        n1_c = '0;
        for (int unsigned i = 0; i < 8; i++) n1_c += 4'(qm_c[i]);
        n0_c = 4'd8 - n1_c;

        case (mode)
            VIDEO_GUARD:  sym_c = video_guard(CHANNEL);
            ISLAND:       sym_c = terc4(data_island_data);
            ISLAND_GUARD: sym_c = data_guard(CHANNEL, guard_ctrl);
            default:      sym_c = control_code(control_data);
        endcase
    end

    if (PIPELINED != 0) begin : g_reg
        // Symbol register resets to the control-00 code so it agrees with the forced CONTROL mode.
        always_ff @(posedge clk_pixel or negedge reset_n) begin
            if (!reset_n) begin
                q_m     <= '0;
                n1      <= '0;
                n0      <= '0;
                symbol  <= CTRL_00;
                mode_s1 <= CONTROL;
            end else begin
                q_m     <= qm_c;
                n1      <= n1_c;
                n0      <= n0_c;
                symbol  <= sym_c;
                mode_s1 <= mode;
            end
        end
    end else begin : g_comb
        assign q_m     = qm_c;
        assign n1      = n1_c;
        assign n0      = n0_c;
        assign symbol  = sym_c;
        assign mode_s1 = mode;
    end

endmodule

// File: rtl/tmds_channel_array.sv
// N-lane TMDS encoder: shared mode select, per-lane running disparity and
// registered symbol output.
module tmds_channel_array
    import tmds_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int PIPELINED    = 1
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    tmds_channel_array_if.slave  bus
);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        logic [8:0]        q_m;
        logic [3:0]        n1;
        logic [3:0]        n0;
        logic [9:0]        symbol;
        logic [2:0]        mode_s1;
        logic [9:0]        tmds_q;
        logic [9:0]        video_sym;
        logic signed [4:0] acc;
        logic signed [4:0] acc_add;
        logic signed [4:0] diff;

        tmds_video_stage1 #(
            .CHANNEL   (c),
            .PIPELINED (PIPELINED)
        ) u_stage1 (
            .clk_pixel        (clk_pixel),
            .reset_n          (reset_n),
            .video_data       (bus.video_data[8*c +: 8]),
            .data_island_data (bus.data_island_data[4*c +: 4]),
            .control_data     (bus.control_data[2*c +: 2]),
            .guard_ctrl       (bus.control_data[1:0]),
            .mode             (bus.mode),
            .q_m              (q_m),
            .n1               (n1),
            .n0               (n0),
            .symbol           (symbol),
            .mode_s1          (mode_s1)
        );

        always_comb begin
            diff = $signed({1'b0, n1}) - $signed({1'b0, n0});
            if ((acc == 5'sd0) || (n1 == n0)) begin
                video_sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                acc_add   = q_m[8] ? diff : -diff;
            end else if ((!acc[4] && (n1 > n0)) || (acc[4] && (n1 < n0))) begin
                video_sym = {1'b1, q_m[8], ~q_m[7:0]};
                acc_add   = -diff + (q_m[8] ? 5'sd2 : 5'sd0);
            end else begin
                video_sym = {1'b0, q_m[8], q_m[7:0]};
                acc_add   = diff - (q_m[8] ? 5'sd0 : 5'sd2);
            end
        end

        // Illegal modes keep the last symbol on the wire but still clear disparity.
        always_ff @(posedge clk_pixel or negedge reset_n) begin
            if (!reset_n) begin
                tmds_q <= CTRL_00;
                acc    <= '0;
            end else if (mode_s1 == VIDEO) begin
                tmds_q <= video_sym;
                acc    <= acc + acc_add;
            end else begin
                acc <= '0;
                if (mode_s1 <= ISLAND_GUARD) tmds_q <= symbol;
            end
        end

        assign bus.tmds[10*c +: 10]     = tmds_q;
        assign bus.disparity[5*c +: 5] = acc;
    end

endmodule

// File: tb/tb_tmds_channel_array.sv
// Directed bench driving four encoder variants (1/3 lanes x latency 1/2)
// from one stimulus stream.
module tb_tmds_channel_array;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] vd;
    logic [11:0] di;
    logic [5:0]  cd;
    logic [2:0]  md;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] C00 = 10'b1101010100;

    logic [9:0] seq_t [3];
    logic [4:0] seq_d [3];

    always #5 clk = ~clk;

    tmds_channel_array_if #(.NUM_CHANNELS(3)) if_a ();
    tmds_channel_array_if #(.NUM_CHANNELS(3)) if_b ();
    tmds_channel_array_if #(.NUM_CHANNELS(1)) if_c ();
    tmds_channel_array_if #(.NUM_CHANNELS(1)) if_d ();

    assign if_a.video_data = vd;      assign if_b.video_data = vd;
    assign if_c.video_data = vd[7:0]; assign if_d.video_data = vd[7:0];
    assign if_a.data_island_data = di;      assign if_b.data_island_data = di;
    assign if_c.data_island_data = di[3:0]; assign if_d.data_island_data = di[3:0];
    assign if_a.control_data = cd;      assign if_b.control_data = cd;
    assign if_c.control_data = cd[1:0]; assign if_d.control_data = cd[1:0];
    assign if_a.mode = md; assign if_b.mode = md; assign if_c.mode = md; assign if_d.mode = md;

    tmds_channel_array #(.NUM_CHANNELS(3), .PIPELINED(0)) dut_a (.clk_pixel(clk), .reset_n(reset_n), .bus(if_a));
    tmds_channel_array #(.NUM_CHANNELS(3), .PIPELINED(1)) dut_b (.clk_pixel(clk), .reset_n(reset_n), .bus(if_b));
    tmds_channel_array #(.NUM_CHANNELS(1), .PIPELINED(0)) dut_c (.clk_pixel(clk), .reset_n(reset_n), .bus(if_c));
    tmds_channel_array #(.NUM_CHANNELS(1), .PIPELINED(1)) dut_d (.clk_pixel(clk), .reset_n(reset_n), .bus(if_d));

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // on_p0 selects the latency-1 instances, on_p1 the latency-2 instances.
    task automatic chk_sym(input string tag, input int lane, input bit on_p0, input bit on_p1,
                           input logic [9:0] et, input logic [4:0] ed);
        if (on_p0) begin
            chk({tag, " a.tmds"}, 32'(if_a.tmds[lane*10 +: 10]), 32'(et));
            chk({tag, " a.disp"}, 32'(if_a.disparity[lane*5 +: 5]), 32'(ed));
            if (lane == 0) begin
                chk({tag, " c.tmds"}, 32'(if_c.tmds), 32'(et));
                chk({tag, " c.disp"}, 32'(if_c.disparity), 32'(ed));
            end
        end
        if (on_p1) begin
            chk({tag, " b.tmds"}, 32'(if_b.tmds[lane*10 +: 10]), 32'(et));
            chk({tag, " b.disp"}, 32'(if_b.disparity[lane*5 +: 5]), 32'(ed));
            if (lane == 0) begin
                chk({tag, " d.tmds"}, 32'(if_d.tmds), 32'(et));
                chk({tag, " d.disp"}, 32'(if_d.disparity), 32'(ed));
            end
        end
    endtask

    task automatic chk_all(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                           input logic [9:0] e2, input logic [4:0] ed);
        chk_sym({tag, " l0"}, 0, 1'b1, 1'b1, e0, ed);
        chk_sym({tag, " l1"}, 1, 1'b1, 1'b1, e1, ed);
        chk_sym({tag, " l2"}, 2, 1'b1, 1'b1, e2, ed);
    endtask

    task automatic video_first(input string tag, input logic [7:0] b,
                               input logic [9:0] et, input logic [4:0] ed);
        md = 3'd0;
        tick; tick;
        md = 3'd1;
        vd = {3{b}};
        tick;
        chk_sym({tag, " p0"}, 0, 1'b1, 1'b0, et, ed);
        tick;
        chk_sym({tag, " p1"}, 0, 1'b0, 1'b1, et, ed);
        md = 3'd0;
    endtask

    initial begin
        seq_t[0] = 10'b0100000000; seq_d[0] = 5'b11000;
        seq_t[1] = 10'b1111111111; seq_d[1] = 5'b00010;
        seq_t[2] = 10'b0100000000; seq_d[2] = 5'b11010;

        reset_n = 1'b0;
        vd = 24'($urandom);
        di = 12'($urandom);
        cd = 6'($urandom);
        md = 3'($urandom_range(0, 7));
        tick; tick; tick;
        chk_all("reset", C00, C00, C00, 5'd0);

        reset_n = 1'b1;
        md = 3'd0;
        cd = 6'b000011;
        tick;
        chk_sym("ctrl11 lat1", 0, 1'b1, 1'b0, 10'b1010101011, 5'd0);
        tick;
        chk_all("ctrl11", 10'b1010101011, C00, C00, 5'd0);

        md = 3'd2;
        tick;
        chk_sym("vguard lat1 new", 0, 1'b1, 1'b0, 10'b1011001100, 5'd0);
        chk_sym("vguard lat1 old", 0, 1'b0, 1'b1, 10'b1010101011, 5'd0);
        tick;
        chk_all("vguard", 10'b1011001100, 10'b0100110011, 10'b1011001100, 5'd0);

        md = 3'd4;
        cd = 6'b000010;
        tick; tick;
        chk_all("iguard", 10'b0101100011, 10'b0100110011, 10'b0100110011, 5'd0);

        md = 3'd3;
        di = 12'h555;
        tick; tick;
        chk_all("terc4 5", 10'b0100011110, 10'b0100011110, 10'b0100011110, 5'd0);
        di = 12'hFFF;
        tick; tick;
        chk_all("terc4 F", 10'b1011000011, 10'b1011000011, 10'b1011000011, 5'd0);
        di = 12'h0C8;
        tick; tick;
        chk_all("terc4 mix", 10'b1011001100, 10'b1010001110, 10'b1010011100, 5'd0);

        md = 3'd0;
        tick; tick;
        md = 3'd1;
        vd = 24'h000000;
        for (int t = 1; t <= 4; t++) begin
            tick;
            if (t <= 3) chk_sym($sformatf("vid00 s%0d", t - 1), 0, 1'b1, 1'b0, seq_t[t-1], seq_d[t-1]);
            if (t >= 2) chk_sym($sformatf("vid00 s%0d", t - 2), 0, 1'b0, 1'b1, seq_t[t-2], seq_d[t-2]);
        end

        md = 3'd0;
        tick;
        chk_sym("gap ctrl", 0, 1'b1, 1'b0, 10'b0101010100, 5'd0);
        md = 3'd1;
        tick;
        chk_sym("gap first", 0, 1'b1, 1'b0, 10'b0100000000, 5'b11000);
        chk_sym("gap ctrl", 0, 1'b0, 1'b1, 10'b0101010100, 5'd0);
        tick;
        chk_sym("gap first", 0, 1'b0, 1'b1, 10'b0100000000, 5'b11000);

        video_first("xFF", 8'hFF, 10'b1000000000, 5'b11000);
        video_first("x1E", 8'h1E, 10'b1001011111, 5'b00100);
        video_first("x1F", 8'h1F, 10'b1010100000, 5'b11100);
        video_first("x0F", 8'h0F, 10'b0100000101, 5'b11100);

        tick; tick;
        md = 3'd1;
        vd = 24'h000000;
        tick;
        chk_sym("ill pre", 0, 1'b1, 1'b0, 10'b0100000000, 5'b11000);
        md = 3'd6;
        tick;
        chk_sym("ill hold", 0, 1'b1, 1'b0, 10'b0100000000, 5'd0);
        chk_sym("ill pre", 0, 1'b0, 1'b1, 10'b0100000000, 5'b11000);
        tick;
        chk_sym("ill hold2", 0, 1'b1, 1'b1, 10'b0100000000, 5'd0);

        md = 3'd3;
        di = 12'h555;
        tick; tick;
        md = 3'd7;
        tick; tick;
        chk_all("ill island", 10'b0100011110, 10'b0100011110, 10'b0100011110, 5'd0);

        md = 3'd1;
        vd = 24'hA53C0F;
        tick; tick; tick;
        reset_n = 1'b0;
        #1;
        chk_all("async rst", C00, C00, C00, 5'd0);
        tick;
        reset_n = 1'b1;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
